// File: rtl/retire_trace_buffer_if.sv
// Trace stream from the retire buffer to the debug host: FWFT head record plus valid/ready.
// master = buffer side (drives the head record), slave = host side (drives ready).
interface retire_trace_buffer_if;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [31:0] trace_data;
    logic [31:0] trace_addr;
    logic [2:0]  trace_flags;

    modport master (
        output trace_valid, trace_pc, trace_data, trace_addr, trace_flags,
        input  trace_ready
    );

    modport slave (
        input  trace_valid, trace_pc, trace_data, trace_addr, trace_flags,
        output trace_ready
    );
endinterface

// File: rtl/retire_trace_buffer.sv
// Captures each retired WB instruction as a trace record into a FWFT FIFO; halts after ebreak until resume.
// Latency: record visible on the trace head the cycle after capture. Optional macro TRACE_FILTER_EN records only writers/ebreak.
// Backpressure: stall_req freezes the pipeline combinationally when full (a same-cycle pop frees space) or while halted.
module retire_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int CNTW  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wb_nop,
    input  logic [31:0]              wb_pc,
    input  logic [31:0]              wb_din,
    input  logic                     wb_reg_write,
    input  logic [4:0]               wb_rd,
    input  logic                     wb_ebreak,
    input  logic [31:0]              wb_mem_din,
    input  logic [31:0]              wb_mem_wa,
    input  logic                     wb_mem_we,
    input  logic                     resume,
    output logic                     stall_req,
    output logic                     halted,
    retire_trace_buffer_if.master    trace,
    output logic [$clog2(DEPTH):0]   fill,
    output logic [CNTW-1:0]          retired_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic [31:0] addr;
        logic [2:0]  flags;
    } rec_t;

    rec_t            mem [DEPTH];
    rec_t            wr_rec;
    rec_t            head;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            pop;
    logic            space;
    logic            rec_en;
    logic            retire;
    logic            push;

`ifdef TRACE_FILTER_EN
    // Only architecturally visible effects are worth a FIFO slot.
    assign rec_en = (wb_reg_write & (wb_rd != 5'd0)) | wb_mem_we | wb_ebreak;
`else
    assign rec_en = 1'b1;
`endif

    always_comb begin
        wr_rec       = '0;
        wr_rec.pc    = wb_pc;
        wr_rec.data  = wb_mem_we ? wb_mem_din : wb_din;
        wr_rec.addr  = wb_mem_we ? wb_mem_wa : {27'b0, wb_rd};
        wr_rec.flags = {wb_ebreak, wb_mem_we, wb_reg_write};
    end

    assign head              = (fill != '0) ? mem[rd_ptr] : '0;
    assign trace.trace_valid = (fill != '0);
    assign trace.trace_pc    = head.pc;
    assign trace.trace_data  = head.data;
    assign trace.trace_addr  = head.addr;
    assign trace.trace_flags = head.flags;

    // A pop in the same cycle frees a slot, so trace_ready feeds stall_req on purpose.
    assign pop       = trace.trace_valid & trace.trace_ready;
    assign space     = (fill < FW'(DEPTH)) | pop;
    assign retire    = ~wb_nop & ~halted & (space | ~rec_en);
    assign push      = retire & rec_en;
    assign stall_req = ~wb_nop & (halted | (rec_en & ~space));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fill        <= '0;
            halted      <= 1'b0;
            retired_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fill <= fill + FW'(1);
                2'b01:   fill <= fill - FW'(1);
                default: fill <= fill;
            endcase
            if (retire) retired_cnt <= retired_cnt + CNTW'(1);
            // Halt set by an ebreak capture takes priority over a coincident resume.
            if (retire & wb_ebreak) halted <= 1'b1;
            else if (resume)        halted <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_rec;
    end
endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed and randomized bench for retire_trace_buffer against a queue-based reference model.
module tb_retire_trace_buffer;
    localparam int DEPTH = 16;
    localparam int CNTW  = 32;

    typedef struct {
        bit        nop;
        bit [31:0] pc;
        bit [31:0] din;
        bit        rw;
        bit [4:0]  rd;
        bit        eb;
        bit [31:0] mdin;
        bit [31:0] mwa;
        bit        mwe;
    } wb_t;

    typedef struct {
        bit [31:0] pc;
        bit [31:0] data;
        bit [31:0] addr;
        bit [2:0]  flags;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_nop, wb_reg_write, wb_ebreak, wb_mem_we, resume;
    logic [31:0] wb_pc, wb_din, wb_mem_din, wb_mem_wa;
    logic [4:0]  wb_rd;
    logic        stall_req, halted;
    logic [$clog2(DEPTH):0] fill;
    logic [CNTW-1:0] retired_cnt;

    retire_trace_buffer_if ifc ();

    retire_trace_buffer #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_nop(wb_nop), .wb_pc(wb_pc), .wb_din(wb_din), .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd), .wb_ebreak(wb_ebreak), .wb_mem_din(wb_mem_din), .wb_mem_wa(wb_mem_wa),
        .wb_mem_we(wb_mem_we), .resume(resume), .stall_req(stall_req), .halted(halted),
        .trace(ifc.master), .fill(fill), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    int        tests = 0;
    int        fails = 0;
    rec_t      m_q[$];
    bit [31:0] m_cnt;
    bit        m_halt;
    bit        m_pop, m_push, m_retire, m_stall, m_set_halt, m_resume;
    rec_t      m_new;
    wb_t       cur;
    bit [31:0] base;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply(input wb_t w);
        wb_nop = w.nop; wb_pc = w.pc; wb_din = w.din; wb_reg_write = w.rw; wb_rd = w.rd;
        wb_ebreak = w.eb; wb_mem_din = w.mdin; wb_mem_wa = w.mwa; wb_mem_we = w.mwe;
    endtask

    function automatic wb_t mk(input bit nop, input bit [31:0] pc, input bit [31:0] din, input bit rw,
                               input bit [4:0] rd, input bit eb, input bit mwe,
                               input bit [31:0] mdin, input bit [31:0] mwa);
        wb_t w;
        w.nop = nop; w.pc = pc; w.din = din; w.rw = rw; w.rd = rd;
        w.eb = eb; w.mwe = mwe; w.mdin = mdin; w.mwa = mwa;
        return w;
    endfunction

    function automatic wb_t rand_wb(input bit allow_eb);
        return mk(($urandom % 4) == 0, $urandom, $urandom, 1'($urandom % 2), 5'($urandom % 32),
                  allow_eb && (($urandom % 24) == 0), ($urandom % 4) == 0, $urandom, $urandom);
    endfunction

    function automatic wb_t alu(input bit [31:0] pc);
        return mk(1'b0, pc, $urandom, 1'b1, 5'(1 + $urandom % 31), 1'b0, 1'b0, 32'h0, 32'h0);
    endfunction

    // Reference: decide this cycle's behaviour from the rules and compare every output.
    task automatic half();
        bit   vld, space, rec_en;
        rec_t hd;
        @(negedge clk);
        vld    = m_q.size() != 0;
        m_pop  = vld && ifc.trace_ready;
        space  = (m_q.size() < DEPTH) || m_pop;
`ifdef TRACE_FILTER_EN
        rec_en = (wb_reg_write && wb_rd != 0) || wb_mem_we || wb_ebreak;
`else
        rec_en = 1'b1;
`endif
        m_retire   = !wb_nop && !m_halt && (space || !rec_en);
        m_push     = m_retire && rec_en;
        m_stall    = !wb_nop && (m_halt || (rec_en && !space));
        m_set_halt = m_retire && wb_ebreak;
        m_resume   = resume;
        m_new.pc    = wb_pc;
        m_new.data  = wb_mem_we ? wb_mem_din : wb_din;
        m_new.addr  = wb_mem_we ? wb_mem_wa : {27'b0, wb_rd};
        m_new.flags = {wb_ebreak, wb_mem_we, wb_reg_write};
        hd = '{32'h0, 32'h0, 32'h0, 3'h0};
        if (vld) hd = m_q[0];
        chk("stall_req",   stall_req,         m_stall);
        chk("halted",      halted,            m_halt);
        chk("fill",        fill,              m_q.size());
        chk("trace_valid", ifc.trace_valid,   vld);
        chk("trace_pc",    ifc.trace_pc,      hd.pc);
        chk("trace_data",  ifc.trace_data,    hd.data);
        chk("trace_addr",  ifc.trace_addr,    hd.addr);
        chk("trace_flags", ifc.trace_flags,   hd.flags);
        chk("retired_cnt", retired_cnt,       m_cnt);
    endtask

    task automatic tick();
        @(posedge clk);
        if (m_pop)    void'(m_q.pop_front());
        if (m_push)   m_q.push_back(m_new);
        if (m_retire) m_cnt++;
        if (m_set_halt)    m_halt = 1'b1;
        else if (m_resume) m_halt = 1'b0;
        #1;
    endtask

    task automatic cycle();
        half();
        tick();
    endtask

    task automatic drain();
        apply(mk(1'b1, 0, 0, 0, 0, 0, 0, 0, 0));
        ifc.trace_ready = 1'b1;
        for (int k = 0; k < 2 * DEPTH && m_q.size() != 0; k++) cycle();
        chk("drain_empty", fill, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        resume = 1'b0;
        ifc.trace_ready = 1'b0;
        apply(mk(1'b1, 0, 0, 0, 0, 0, 0, 0, 0));
        m_cnt = 0; m_halt = 0;
        #12;
        chk("rst_fill", fill, 0);
        chk("rst_valid", ifc.trace_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_cnt", retired_cnt, 0);
        chk("rst_head_pc", ifc.trace_pc, 0);
        chk("rst_stall", stall_req, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // addi x5 at 0x10
        ifc.trace_ready = 1'b1;
        apply(mk(1'b0, 32'h10, 32'h7, 1'b1, 5'd5, 1'b0, 1'b0, 0, 0));
        cycle();
        apply(mk(1'b1, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("addi_valid", ifc.trace_valid, 1);
        chk("addi_pc", ifc.trace_pc, 32'h10);
        chk("addi_data", ifc.trace_data, 32'h7);
        chk("addi_addr", ifc.trace_addr, 32'h5);
        chk("addi_flags", ifc.trace_flags, 3'b001);
        chk("addi_cnt", retired_cnt, 1);
        cycle();

        // store at 0x20
        ifc.trace_ready = 1'b0;
        apply(mk(1'b0, 32'h20, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h1000));
        cycle();
        apply(mk(1'b1, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("st_data", ifc.trace_data, 32'hDEADBEEF);
        chk("st_addr", ifc.trace_addr, 32'h1000);
        chk("st_flags", ifc.trace_flags, 3'b010);
        drain();

        // 17 back-to-back retirements into a stalled host
        base = m_cnt;
        ifc.trace_ready = 1'b0;
        for (int n = 0; n < 17; n++) begin
            cur = alu(32'h100 + 32'(4 * n));
            apply(cur);
            half();
            if (n == 16) begin
                chk("full_stall", stall_req, 1);
                chk("full_fill", fill, DEPTH);
            end
            tick();
        end
        ifc.trace_ready = 1'b1;
        half();
        chk("full_pop_nostall", stall_req, 0);
        tick();
        ifc.trace_ready = 1'b0;
        apply(mk(1'b1, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("full_fill_after", fill, DEPTH);
        chk("full_cnt", retired_cnt, base + 17);
        cycle();
        drain();

        // ebreak halt and resume
        ifc.trace_ready = 1'b1;
        apply(mk(1'b0, 32'h40, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0, 0, 0));
        cycle();
        base = m_cnt;
        apply(alu(32'h44));
        half();
        chk("eb_halted", halted, 1);
        chk("eb_stall", stall_req, 1);
        tick();
        cycle();
        resume = 1'b1;
        half();
        chk("eb_stall_resume", stall_req, 1);
        tick();
        resume = 1'b0;
        half();
        chk("eb_released", halted, 0);
        chk("eb_nostall", stall_req, 0);
        tick();
        chk("eb_cnt", retired_cnt, base + 1);
        drain();

        // async reset with 5 records and halted
        ifc.trace_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            apply(alu(32'h200 + 32'(4 * n)));
            cycle();
        end
        apply(mk(1'b0, 32'h210, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0, 0, 0));
        cycle();
        apply(alu(32'h214));
        half();
        chk("pre_rst_fill", fill, 5);
        chk("pre_rst_halted", halted, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_fill", fill, 0);
        chk("arst_valid", ifc.trace_valid, 0);
        chk("arst_halted", halted, 0);
        chk("arst_cnt", retired_cnt, 0);
        m_q.delete(); m_cnt = 0; m_halt = 0;
        apply(mk(1'b1, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        rst_n = 1'b1;

`ifdef TRACE_FILTER_EN
        ifc.trace_ready = 1'b0;
        for (int k = 0; k < 2 * DEPTH && m_q.size() < DEPTH; k++) begin
            apply(alu(32'h300 + 32'(4 * k)));
            cycle();
        end
        base = m_cnt;
        apply(mk(1'b0, 32'h380, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 0, 0));
        half();
        chk("flt_branch_stall", stall_req, 0);
        tick();
        apply(mk(1'b0, 32'h384, 32'h9, 1'b1, 5'd0, 1'b0, 1'b0, 0, 0));
        half();
        chk("flt_x0_stall", stall_req, 0);
        tick();
        chk("flt_fill", fill, DEPTH);
        chk("flt_cnt", retired_cnt, base + 2);
        drain();
`endif

        // randomized traffic with a pipeline that holds stalled instructions
        cur = rand_wb(1'b1);
        for (int i = 0; i < 600; i++) begin
            ifc.trace_ready = ($urandom % 4) != 0;
            if (i % 150 < 40) ifc.trace_ready = ($urandom % 6) == 0;
            resume = m_halt && (($urandom % 5) == 0);
            apply(cur);
            cycle();
            if (!m_stall) cur = rand_wb(1'b1);
        end
        resume = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
